// File: rtl/word_queue.sv
`default_nettype none
// ============================================================================
// Module   : word_queue
// Purpose  : Circular FIFO behind the deserializer. Each word is accepted
//            through a ready/ack handshake and released in order on dequeue.
//            Optional macro WORD_QUEUE_DROP_OLDEST_EN: overwrite the oldest
//            entry when a word arrives while full.
// Revision : 1.0 - initial release
// ============================================================================
module word_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock_100KHz,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     enqueue_in,
    output logic                     ack_out,
    input  logic                     dequeue_in,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   len_out,
    output logic                     full_out,
    output logic                     empty_out
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_data_out;
    logic                 r_ack;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_space;
    logic                 w_enq_fire;
    logic                 w_deq_fire;
    logic                 w_overwrite;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);

`ifdef WORD_QUEUE_DROP_OLDEST_EN
    assign w_space = 1'b1;
`else
    assign w_space = !w_full;
`endif

    assign w_deq_fire  = dequeue_in && !w_empty;
    // A write into a full queue with no dequeue displaces the head entry.
    assign w_overwrite = w_enq_fire && w_full && !w_deq_fire;

    always_comb begin
        w_state_next = r_state;
        w_enq_fire   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enqueue_in && w_space) begin
                    w_enq_fire   = 1'b1;
                    w_state_next = ST_ACK;
                end
            end
            ST_ACK:  w_state_next = ST_HOLD;
            // Wait for the upstream ready flag to drop so one word is never captured twice.
            ST_HOLD: begin
                if (!enqueue_in) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_100KHz or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ack      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_data_out <= '0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_enq_fire;
            if (w_enq_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq_fire) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
            if (w_deq_fire || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enq_fire && !w_deq_fire && !w_full) begin
                r_count <= r_count + 1'b1;
            end else if (w_deq_fire && !w_enq_fire) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage carries no reset; its contents are don't-care until written.
    always_ff @(posedge clock_100KHz) begin
        if (w_enq_fire) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign ack_out   = r_ack;
    assign data_out  = r_data_out;
    assign len_out   = r_count;
    assign full_out  = w_full;
    assign empty_out = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_word_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_word_queue
// Purpose  : Self-checking bench for word_queue (default build): vector table,
//            directed corner sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_word_queue;

    logic       clock_100KHz;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       ack_out;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;

    int checks;
    int errors;

    word_queue #(.DEPTH(8), .WIDTH(8)) dut (
        .clock_100KHz (clock_100KHz),
        .reset        (reset),
        .data_in      (data_in),
        .enqueue_in   (enqueue_in),
        .ack_out      (ack_out),
        .dequeue_in   (dequeue_in),
        .data_out     (data_out),
        .len_out      (len_out),
        .full_out     (full_out),
        .empty_out    (empty_out)
    );

    initial clock_100KHz = 1'b0;
    always #5 clock_100KHz = ~clock_100KHz;

    typedef struct packed {
        logic       enq;
        logic       deq;
        logic [7:0] din;
        logic       e_ack;
        logic [3:0] e_len;
        logic [7:0] e_dout;
        logic       e_full;
        logic       e_empty;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_100KHz);
        @(negedge clock_100KHz);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        data_in    = 8'h00;
        repeat (2) @(negedge clock_100KHz);
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [7:0] d);
        int n;
        n          = 0;
        enqueue_in = 1'b1;
        data_in    = d;
        tick();
        while (!ack_out && n < 20) begin
            tick();
            n++;
        end
        check("push_ack", 32'(ack_out), 32'd1);
        enqueue_in = 1'b0;
        tick();
        tick();
    endtask

    logic [7:0] q [$];
    logic [7:0] exp_dout;
    bit         low_seen;
    bit         pending;
    bit         acc;
    bit         deq_ok;
    int         since_cap;
    int         cnt;

    initial begin
        checks = 0;
        errors = 0;
        do_reset();

        check("rst_ack",   32'(ack_out),   32'd0);
        check("rst_dout",  32'(data_out),  32'd0);
        check("rst_len",   32'(len_out),   32'd0);
        check("rst_full",  32'(full_out),  32'd0);
        check("rst_empty", 32'(empty_out), 32'd1);

        // Single word, empty dequeue, held request
        vecs[0] = '{1'b1, 1'b0, 8'h41, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 8'h41, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'h41, 1'b0, 4'd0, 8'h41, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 8'h41, 1'b0, 4'd0, 8'h41, 1'b0, 1'b1};
        for (int i = 4; i < 14; i++) begin
            vecs[i] = '{1'b1, 1'b0, 8'h55, (i == 4), 4'd1, 8'h41, 1'b0, 1'b0};
        end
        vecs[14] = '{1'b0, 1'b0, 8'h55, 1'b0, 4'd1, 8'h41, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 8'h55, 1'b0, 4'd0, 8'h55, 1'b0, 1'b1};

        for (int i = 0; i < 16; i++) begin
            enqueue_in = vecs[i].enq;
            dequeue_in = vecs[i].deq;
            data_in    = vecs[i].din;
            tick();
            check("vec_ack",   32'(ack_out),   32'(vecs[i].e_ack));
            check("vec_len",   32'(len_out),   32'(vecs[i].e_len));
            check("vec_dout",  32'(data_out),  32'(vecs[i].e_dout));
            check("vec_full",  32'(full_out),  32'(vecs[i].e_full));
            check("vec_empty", 32'(empty_out), 32'(vecs[i].e_empty));
        end
        dequeue_in = 1'b0;

        // Fill, stall while full, then wrap
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            push_word(8'(k));
        end
        check("fill_full", 32'(full_out), 32'd1);
        check("fill_len",  32'(len_out),  32'd8);
        enqueue_in = 1'b1;
        data_in    = 8'h09;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stall_ack", 32'(ack_out), 32'd0);
        end
        dequeue_in = 1'b1;
        tick();
        check("full_deq_dout", 32'(data_out), 32'h01);
        check("full_deq_len",  32'(len_out),  32'd7);
        check("full_deq_ack",  32'(ack_out),  32'd0);
        dequeue_in = 1'b0;
        tick();
        check("late_ack", 32'(ack_out), 32'd1);
        check("late_len", 32'(len_out), 32'd8);
        enqueue_in = 1'b0;
        tick();
        tick();
        dequeue_in = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            tick();
            check("drain_dout", 32'(data_out), 32'(k));
        end
        dequeue_in = 1'b0;
        check("drain_empty", 32'(empty_out), 32'd1);
        check("drain_len",   32'(len_out),   32'd0);

        // Reset while the ack pulse is high
        enqueue_in = 1'b1;
        data_in    = 8'h77;
        tick();
        check("mid_ack_pre", 32'(ack_out), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_ack",  32'(ack_out),  32'd0);
        check("mid_rst_len",  32'(len_out),  32'd0);
        check("mid_rst_dout", 32'(data_out), 32'd0);
        @(negedge clock_100KHz);
        reset = 1'b0;
        tick();
        check("post_rst_ack", 32'(ack_out), 32'd1);
        check("post_rst_len", 32'(len_out), 32'd1);
        enqueue_in = 1'b0;
        tick();
        tick();

        // Concurrent enqueue and dequeue at occupancy 3
        do_reset();
        push_word(8'h10);
        push_word(8'h20);
        push_word(8'h30);
        check("conc_len_pre", 32'(len_out), 32'd3);
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        data_in    = 8'hAA;
        tick();
        check("conc_len",  32'(len_out),  32'd3);
        check("conc_dout", 32'(data_out), 32'h10);
        check("conc_ack",  32'(ack_out),  32'd1);
        enqueue_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("conc_drain", 32'(data_out), (k == 0) ? 32'h20 : (k == 1) ? 32'h30 : 32'hAA);
        end
        dequeue_in = 1'b0;

        // Randomized traffic against a rule-level model
        do_reset();
        q.delete();
        exp_dout  = 8'h00;
        low_seen  = 1'b1;
        pending   = 1'b0;
        since_cap = 100;
        for (int c = 0; c < 400; c++) begin
            if (!pending) begin
                enqueue_in = 1'($urandom_range(0, 1));
                if (enqueue_in) begin
                    data_in = 8'($urandom);
                end
                pending = enqueue_in && low_seen;
            end
            dequeue_in = ($urandom_range(0, 9) < 4);

            if (since_cap < 100) since_cap++;
            cnt = q.size();
            if (!enqueue_in && since_cap >= 2) low_seen = 1'b1;
            acc    = enqueue_in && low_seen && (cnt < 8);
            deq_ok = dequeue_in && (cnt > 0);
            if (deq_ok) exp_dout = q.pop_front();
            if (acc) begin
                q.push_back(data_in);
                low_seen  = 1'b0;
                since_cap = 0;
                pending   = 1'b0;
            end

            tick();
            check("rnd_ack",   32'(ack_out),   32'(acc));
            check("rnd_len",   32'(len_out),   32'(q.size()));
            check("rnd_dout",  32'(data_out),  32'(exp_dout));
            check("rnd_full",  32'(full_out),  32'(q.size() == 8));
            check("rnd_empty", 32'(empty_out), 32'(q.size() == 0));
        end
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
